display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed seven-segment scan driver. Sits directly downstream of `calc_top`: consumes its `displays` array (8 digits × 7 segments, already segment-encoded) and drives one physical 8-digit multiplexed display through shared segment lines and per-digit enables. Adds:
- frame-coherent snapshotting, so no digit tears mid-scan;
- an inter-digit blanking cycle against ghosting;
- a whole-display blink option.

## Interface
- `DIGIT_CYCLES`, default 4: clock cycles each digit slot lasts; legal range ≥ 2.
- `BLINK_SCANS`, default 64: full frames per blink half-period; legal range ≥ 1.
- `ACTIVE_LOW`, default 1: 1 = `an`/`seg` asserted low; 0 = asserted high.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `displays`  in  [6:0] × [7:0]  segment patterns from the calculator; bit = 1 means segment lit; index i is digit i.
- `blink`  in  1  when 1, the display flashes at the blink rate.
- `an`  out  8  digit enables; bit i selects digit i.
- `seg`  out  7  shared segment lines, same bit order as `displays[i]`.
- `frame_tick`  out  1  single-cycle pulse in the last cycle of every frame.

## Operation
- State registers:
  - `cnt`: 0..DIGIT_CYCLES-1, slot cycle counter.
  - `idx`: 0..7, current digit.
  - `snap[7:0][6:0]`: frame snapshot.
  - `fcnt`: 0..BLINK_SCANS-1, frame counter.
  - `phase`: blink phase.
- Every edge: `cnt` increments. When `cnt` = DIGIT_CYCLES-1 it wraps to 0 and `idx` increments; `idx` wraps 7→0.
- Snapshot: `snap` loads all 8 `displays` entries on the edge taken while (`idx`,`cnt`) = (0,0). It holds for the entire frame. Changes to `displays` mid-frame appear only in the next frame.
- Outputs are combinational decodes of registered state only; there is no combinational path from `displays` to the outputs.
- Guard cycle (`cnt` = 0): all `an` inactive, all `seg` inactive.
- Active cycles (`cnt` ≥ 1), with blink masking off:
  - `an` has only bit `idx` active.
  - `seg` = `snap[idx]`, inverted when ACTIVE_LOW = 1.
- `frame_tick` = 1 iff `idx` = 7 and `cnt` = DIGIT_CYCLES-1.
- Blink:
  - On each edge where `frame_tick` = 1, `fcnt` increments.
  - When `fcnt` = BLINK_SCANS-1 at that edge, `fcnt` wraps to 0 and `phase` toggles.
  - If `blink` = 1 and `phase` = 1, all `an` are forced inactive. Scanning, snapshotting and `frame_tick` continue unchanged.
  - The `blink` input acts combinationally on the masking. `phase` and `fcnt` run regardless of `blink`.
- Reset values:
  - `cnt` = 0, `idx` = 0, `fcnt` = 0, `phase` = 0, `snap` all 0.
  - Hence during reset: `an` all inactive (8'hFF when ACTIVE_LOW = 1), `seg` all inactive (7'h7F), `frame_tick` = 0.

## Timing
- Frame length is exactly 8 × DIGIT_CYCLES cycles. Each digit is lit for DIGIT_CYCLES-1 cycles per frame.
- Cycle numbering: cycle 0 is the first cycle after reset deassertion.
- Slot k occupies cycles k·DIGIT_CYCLES … k·DIGIT_CYCLES+DIGIT_CYCLES-1 of the frame.
- Latency from a `displays` change to its appearance on `seg`: 1 cycle minimum (change present at the frame-start edge), 8·DIGIT_CYCLES cycles maximum.
- Blink half-period: BLINK_SCANS × 8 × DIGIT_CYCLES cycles. `phase` first becomes 1 at the cycle after the BLINK_SCANS-th `frame_tick`.
- Reset asserted mid-frame: outputs go inactive immediately (asynchronously) and all state clears. The scan restarts at digit 0 with a fresh snapshot after release.
- `blink` changing mid-frame takes effect in the same cycle. `fcnt` and `phase` are not disturbed.

## Test plan
All scenarios use DIGIT_CYCLES = 4, BLINK_SCANS = 2, ACTIVE_LOW = 1 unless stated.
- **Reset:** pulse `reset` for 2 cycles → during reset and cycle 0: `an` = 8'hFF, `seg` = 7'h7F, `frame_tick` = 0.
- **Basic scan:** `displays[i]` = 7'h01 << (i mod 7), held from before release →
  - cycles 1–3: `an` = 8'hFE, `seg` = 7'h7E;
  - cycle 4: `an` = 8'hFF;
  - cycles 5–7: `an` = 8'hFD, `seg` = 7'h7D;
  - cycle 31: `frame_tick` = 1, the only pulse in cycles 0–31.
- **Snapshot coherence:** change `displays[3]` from 7'h08 to 7'h7F at cycle 10 → cycles 13–15 still show `seg` = 7'h77; cycles 45–47 show `seg` = 7'h00.
- **Blink:** hold `blink` = 1 →
  - `an` scans normally in cycles 0–63;
  - `an` = 8'hFF throughout cycles 64–127;
  - scanning resumes at 128.
  - Dropping `blink` to 0 at cycle 80 → `an` = 8'hFE at cycle 97, the next `idx` = 0 active cycle.
- **Mid-scan reset:** assert `reset` at cycle 21 (digit 5 lit) → `an` = 8'hFF without waiting for an edge. After release, digit 0 is lit at cycle 1 and `frame_tick` is next seen at cycle 31.
- **Polarity:** ACTIVE_LOW = 0, `displays[0]` = 7'h3F → guard `an` = 8'h00; cycles 1–3: `an` = 8'h01, `seg` = 7'h3F.

Source files
------------

// File: rtl/display_scan.sv
// Time-multiplexed 8-digit seven-segment scan driver with per-frame snapshot,
// a blanking guard cycle at the start of every digit slot, and whole-display blink.
module display_scan #(
    parameter int DIGIT_CYCLES = 4,
    parameter int BLINK_SCANS  = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0][6:0] displays,
    input  logic            blink,
    output logic [7:0]      an,
    output logic [6:0]      seg,
    output logic            frame_tick
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int FW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_SCANS - 1);

    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0][6:0] snap;
    logic [FW-1:0]   fcnt;
    logic            phase;
    logic            slot_end;
    logic [7:0]      an_act;
    logic [6:0]      seg_act;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_tick = slot_end && (idx == 3'd7);

    // Snapshot is taken only at the frame-start edge so a frame never mixes two inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if ((idx == 3'd0) && (cnt == '0)) begin
                snap <= displays;
            end
            if (frame_tick) begin
                if (fcnt == FCNT_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Cycle 0 of each slot is a blank guard; blink only gates the digit enables.
    always_comb begin
        an_act  = '0;
        seg_act = '0;
        if (cnt != '0) begin
            seg_act = snap[idx];
            if (!(blink && phase)) begin
                an_act[idx] = 1'b1;
            end
        end
    end

    assign an  = ACTIVE_LOW ? ~an_act  : an_act;
    assign seg = ACTIVE_LOW ? ~seg_act : seg_act;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two instances (active-low and active-high) driven together
// and compared every cycle against a frame/slot arithmetic model of the display.
module tb_display_scan;

    localparam int DC = 4;
    localparam int BS = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            blink = 1'b0;
    logic [7:0][6:0] displays;
    logic [7:0]      an_lo, an_hi;
    logic [6:0]      seg_lo, seg_hi;
    logic            ft_lo, ft_hi;

    int              checks = 0;
    int              failures = 0;
    int              t = 0;
    bit              inReset = 1'b1;
    logic [7:0][6:0] msnap = '0;

    display_scan #(.DIGIT_CYCLES(DC), .BLINK_SCANS(BS), .ACTIVE_LOW(1'b1)) dut_lo (
        .clock(clock), .reset(reset), .displays(displays), .blink(blink),
        .an(an_lo), .seg(seg_lo), .frame_tick(ft_lo)
    );

    display_scan #(.DIGIT_CYCLES(DC), .BLINK_SCANS(BS), .ACTIVE_LOW(1'b0)) dut_hi (
        .clock(clock), .reset(reset), .displays(displays), .blink(blink),
        .an(an_hi), .seg(seg_hi), .frame_tick(ft_hi)
    );

    always #5 clock = ~clock;

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Model: slot and guard from cycle arithmetic, blink phase from completed frame count.
    task automatic checkOutput();
        int         slot;
        int         ph;
        logic [7:0] anAct;
        logic [6:0] segAct;
        logic       ft;
        slot   = (t / DC) % 8;
        ph     = ((t / (8 * DC)) / BS) % 2;
        anAct  = '0;
        segAct = '0;
        ft     = 1'b0;
        if (!inReset && (t % DC) != 0) begin
            segAct = msnap[slot];
            if (!(blink && ph == 1)) anAct = 8'(1 << slot);
        end
        if (!inReset && slot == 7 && (t % DC) == DC - 1) ft = 1'b1;
        checkOne("an_lo", an_lo, ~anAct);
        checkOne("seg_lo", {1'b0, seg_lo}, {1'b0, ~segAct});
        checkOne("ft_lo", {7'b0, ft_lo}, {7'b0, ft});
        checkOne("an_hi", an_hi, anAct);
        checkOne("seg_hi", {1'b0, seg_hi}, {1'b0, segAct});
        checkOne("ft_hi", {7'b0, ft_hi}, {7'b0, ft});
    endtask

    task automatic applyStimulus(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                if ($urandom_range(3) == 0) displays[$urandom_range(7)] = 7'($urandom);
                if ($urandom_range(15) == 0) blink = ~blink;
            end
            @(negedge clock);
            checkOutput();
            if (!inReset && (t % (8 * DC)) == 0) msnap = displays;
            @(posedge clock);
            #1;
            t++;
        end
    endtask

    task automatic holdReset();
        msnap = '0;
        @(posedge clock);
        #1;
        checkOutput();
        @(posedge clock);
        #1;
        checkOutput();
        reset   = 1'b0;
        inReset = 1'b0;
        t       = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) displays[i] = 7'(1 << (i % 7));
        reset   = 1'b1;
        inReset = 1'b1;
        holdReset();

        blink = 1'b1;
        applyStimulus(1, 1'b0);
        #1;
        checkOne("basic_an_c1", an_lo, 8'hFE);
        checkOne("basic_seg_c1", {1'b0, seg_lo}, 8'h7E);
        applyStimulus(9, 1'b0);
        displays[3] = 7'h7F;
        applyStimulus(3, 1'b0);
        #1;
        checkOne("snap_old_c13", {1'b0, seg_lo}, 8'h77);
        applyStimulus(32, 1'b0);
        #1;
        checkOne("snap_new_c45", {1'b0, seg_lo}, 8'h00);
        applyStimulus(35, 1'b0);
        blink = 1'b0;
        applyStimulus(17, 1'b0);
        #1;
        checkOne("blink_off_c97", an_lo, 8'hFE);
        applyStimulus(200, 1'b1);

        reset   = 1'b1;
        #1;
        inReset = 1'b1;
        checkOutput();
        holdReset();
        blink = 1'b0;
        applyStimulus(21, 1'b1);
        reset = 1'b1;
        #1;
        checkOne("midreset_an", an_lo, 8'hFF);
        inReset = 1'b1;
        checkOutput();
        holdReset();
        applyStimulus(40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
